offchip_link_arbiter: RTL and testbench
=======================================

OFFCHIP_LINK_ARBITER -- requirements
Module: offchip_link_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high, with ports named clk and rst.
REQ-002 Parameter CREDITS, default 8, SHALL set the number of link word credits (legal range 1..15).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req0_valid, req1_valid  input  1 each  requester has a word pending.
REQ-006 req0_data, req1_data  input  8 each  requester word; SHALL be held stable while valid and not ready.
REQ-007 req0_ready, req1_ready  output  1 each  word accepted this cycle (valid&&ready).
REQ-008 credit_ret  input  1  single-cycle pulse; far end returns one word credit.
REQ-009 lane_valid  output  1  lane beat present.
REQ-010 lane_data  output  2  lane beat payload.
REQ-011 lane_src  output  1  source requester of the current beat.
REQ-012 lane_last  output  1  final (4th) beat of a word.
REQ-013 credit_cnt  output  4  available credits.
REQ-014 cred_err  output  1  sticky credit-overflow flag.

Function
REQ-015 The FSM SHALL have two states: IDLE and SEND; SEND uses a 2-bit beat counter beat = 0..3.
REQ-016 An accept slot SHALL exist when (state==IDLE or (SEND and beat==3)) and credit_cnt>0, with credit_cnt taken as the registered value.
REQ-017 Arbitration SHALL be round-robin: a sole valid requester wins; if both are valid, the one not granted last wins; last_grant updates only on accept.
REQ-018 In an accept slot, reqN_ready SHALL be asserted combinationally for the winner only; reqN_ready may depend on req0_valid/req1_valid; at most one ready SHALL be high per cycle.
REQ-019 On accept, the block SHALL register the word and source, set state=SEND and beat=0, and decrement credit_cnt.
REQ-020 Beats SHALL be registered outputs; the first beat SHALL appear in the cycle after accept (latency 1).
REQ-021 Beat k (k=0..3) SHALL drive lane_data = {word[k+4], word[k]}.
REQ-022 lane_valid SHALL be 1 for every SEND cycle; lane_last SHALL be 1 iff beat==3; lane_src SHALL be constant across the word.
REQ-023 When beat==3 with no accept, the FSM SHALL return to IDLE; when beat==3 with accept, the next word's beat 0 SHALL follow with no bubble (1 word per 4 cycles).
REQ-024 The lane SHALL have no backpressure; once started, a word SHALL always complete in 4 consecutive cycles.
REQ-025 credit_ret SHALL increment credit_cnt, and a simultaneous accept plus credit_ret SHALL leave credit_cnt unchanged.
REQ-026 When credit_cnt==0, no ready SHALL assert, even if credit_ret is high that cycle; acceptance SHALL resume the following cycle.
REQ-027 credit_ret at credit_cnt==CREDITS without a same-cycle accept SHALL be ignored (no wrap) and SHALL set cred_err, which holds until reset.
REQ-028 credit_ret at credit_cnt==CREDITS with a same-cycle accept SHALL be legal: count unchanged, no error.

Reset
REQ-029 On rst assertion, the block SHALL immediately force state=IDLE, beat=0, lane_valid=0, lane_data=0, lane_src=0, lane_last=0, req0_ready=req1_ready=0, credit_cnt=CREDITS, cred_err=0, last_grant=1 (requester 0 wins first).
REQ-030 Reset mid-word SHALL discard the partial word; it SHALL NOT be retransmitted after reset release.

Verification
REQ-031 Reset, then req0 with 0xA5 -> req0_ready in that cycle; next 4 cycles lane_data=01,10,01,10 with lane_src=0 and lane_last on the 4th beat; credit_cnt=7.
REQ-032 Both requesters continuously valid (0x11 and 0x22) -> grants alternate 0,1,0,1 with no bubble between words; lane_valid high for 16 consecutive cycles.
REQ-033 CREDITS=8, no credit_ret, req0 always valid -> exactly 8 words sent, then credit_cnt=0 and ready stays low; one credit_ret -> the 9th word is accepted the cycle after the pulse.
REQ-034 credit_cnt=0 with beat==3 and credit_ret in the same cycle -> no accept that cycle; FSM goes to IDLE and accepts next cycle; credit_cnt ends 0.
REQ-035 Idle, credit_cnt=8, credit_ret pulse -> credit_cnt stays 8 and cred_err=1 and holds; repeat with a same-cycle accept -> no error.
REQ-036 Assert rst at beat 1 of a word -> lane_valid=0 immediately; after release, credit_cnt=8 and the aborted word is not resent.

Source files
------------

// File: rtl/offchip_link_arbiter.sv
// rtl/offchip_link_arbiter.sv - two-requester round-robin arbiter serializing 8-bit words onto a 2-bit credited lane
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req0_valid/data/ready    requester 0 word handshake (ready is combinational)
//   req1_valid/data/ready    requester 1 word handshake (ready is combinational)
//   credit_ret               one-cycle pulse, far end returns one word credit
//   lane_valid/data/src/last serialized lane beat, four beats per word
//   credit_cnt               credits currently available
//   cred_err                 sticky flag, credit returned while already full
module offchip_link_arbiter #(
  parameter int CREDITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       credit_ret,
  output logic       lane_valid,
  output logic [1:0] lane_data,
  output logic       lane_src,
  output logic       lane_last,
  output logic [3:0] credit_cnt,
  output logic       cred_err
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] beat, beat_nxt;
  logic [7:0] word;
  logic       src;
  logic       last_grant;
  logic       slot;
  logic       winner;
  logic       accept;

  // A new word may start from IDLE or overlap the final beat of the current
  // word, which is what gives back-to-back words with no bubble.
  assign slot = ((state == IDLE) || (beat == 2'd3)) && (credit_cnt != 4'd0);

  // With both requesters pending, favour the one not granted last time.
  assign winner = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

  // Ready is held low during reset even though the reset state offers a slot.
  assign req0_ready = !rst && slot && req0_valid && !winner;
  assign req1_ready = !rst && slot && req1_valid &&  winner;
  assign accept     = req0_ready || req1_ready;

  // State register and word capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= 2'd0;
      word       <= 8'd0;
      src        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      if (accept) begin
        word       <= winner ? req1_data : req0_data;
        src        <= winner;
        last_grant <= winner;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SEND;
          beat_nxt  = 2'd0;
        end
      end
      SEND: begin
        if (beat != 2'd3) begin
          beat_nxt = beat + 2'd1;
        end else begin
          state_nxt = accept ? SEND : IDLE;
          beat_nxt  = 2'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = 2'd0;
      end
    endcase
  end

  // Lane outputs decode purely from registered state.
  always_comb begin
    lane_valid = 1'b0;
    lane_data  = 2'd0;
    lane_src   = 1'b0;
    lane_last  = 1'b0;
    if (state == SEND) begin
      lane_valid = 1'b1;
      lane_data  = {word[{1'b1, beat}], word[{1'b0, beat}]};
      lane_src   = src;
      lane_last  = (beat == 2'd3);
    end
  end

  // Credit counter: a return at full count is dropped and flagged, unless an
  // accept consumes a credit in the same cycle, in which case they cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= 4'(CREDITS);
      cred_err   <= 1'b0;
    end else begin
      if (accept && !credit_ret) begin
        credit_cnt <= credit_cnt - 4'd1;
      end else if (credit_ret && !accept) begin
        if (credit_cnt == 4'(CREDITS)) begin
          cred_err <= 1'b1;
        end else begin
          credit_cnt <= credit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_offchip_link_arbiter.sv
// tb/tb_offchip_link_arbiter.sv - scoreboard bench for offchip_link_arbiter
module tb_offchip_link_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       credit_ret;
  logic       lane_valid;
  logic [1:0] lane_data;
  logic       lane_src;
  logic       lane_last;
  logic [3:0] credit_cnt;
  logic       cred_err;

  int checks = 0;
  int errors = 0;

  // Expected beats: {lane_data, lane_src, lane_last}
  logic [3:0] exp_q[$];
  logic [3:0] mon_e;

  offchip_link_arbiter #(.CREDITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .credit_ret (credit_ret),
    .lane_valid (lane_valid),
    .lane_data  (lane_data),
    .lane_src   (lane_src),
    .lane_last  (lane_last),
    .credit_cnt (credit_cnt),
    .cred_err   (cred_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Beat k of a word carries {word[k+4], word[k]}.
  task automatic push_word(input logic [7:0] w, input logic s);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({w[k+4], w[k], s, (k == 3)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    credit_ret = 1'b0;
    @(negedge clk);
    chk("rst_lane_valid", lane_valid, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_credit_cnt", credit_cnt, 8);
    chk("rst_cred_err", cred_err, 0);
    tick();
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst        = 1'b0;
  endtask

  // Monitor: every lane beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (lane_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL lane_beat: unexpected beat data=%0d src=%0d last=%0d", lane_data, lane_src, lane_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({lane_data, lane_src, lane_last} !== mon_e) begin
          errors++;
          $display("FAIL lane_beat: got data=%0d src=%0d last=%0d expected data=%0d src=%0d last=%0d",
                   lane_data, lane_src, lane_last, mon_e[3:2], mon_e[1], mon_e[0]);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'h00;
    req1_data  = 8'h00;
    credit_ret = 1'b0;
    #1;

    // Single word 0xA5: beats 01,10,01,10 from requester 0.
    do_reset();
    exp_q.push_back(4'b01_0_0);
    exp_q.push_back(4'b10_0_0);
    exp_q.push_back(4'b01_0_0);
    exp_q.push_back(4'b10_0_1);
    req0_valid = 1'b1;
    req0_data  = 8'hA5;
    @(negedge clk);
    chk("s1_ready0", req0_ready, 1);
    chk("s1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("s1_lane_idle", lane_valid, 0);
    chk("s1_credit_cnt", credit_cnt, 7);
    tick();

    // Both requesters valid: grants alternate 0,1,0,1 with no bubble.
    do_reset();
    req0_data = 8'h11;
    req1_data = 8'h22;
    push_word(8'h11, 1'b0);
    push_word(8'h22, 1'b1);
    push_word(8'h11, 1'b0);
    push_word(8'h22, 1'b1);
    for (int t = 0; t <= 17; t++) begin
      req0_valid = (t <= 12);
      req1_valid = (t <= 12);
      @(negedge clk);
      chk("s2_ready0", req0_ready, int'(t <= 12 && t % 4 == 0 && (t / 4) % 2 == 0));
      chk("s2_ready1", req1_ready, int'(t <= 12 && t % 4 == 0 && (t / 4) % 2 == 1));
      chk("s2_lane_valid", lane_valid, int'(t >= 1 && t <= 16));
      tick();
    end
    chk("s2_credit_cnt", credit_cnt, 4);

    // Credit exhaustion, return while empty, and return at final beat while empty.
    do_reset();
    req0_data = 8'h3C;
    for (int i = 0; i < 10; i++) push_word(8'h3C, 1'b0);
    for (int t = 0; t <= 47; t++) begin
      req0_valid = (t <= 42);
      credit_ret = (t == 36 || t == 41);
      @(negedge clk);
      chk("s3_ready0", req0_ready, int'((t <= 28 && t % 4 == 0) || t == 37 || t == 42));
      chk("s3_ready1", req1_ready, 0);
      if (t == 36) chk("s3_credit_empty", credit_cnt, 0);
      if (t == 41) chk("s3_credit_last_beat", credit_cnt, 0);
      tick();
    end
    credit_ret = 1'b0;
    @(negedge clk);
    chk("s3_credit_end", credit_cnt, 0);
    chk("s3_lane_idle", lane_valid, 0);
    tick();

    // Credit return at full count: error when idle, legal with an accept.
    do_reset();
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    @(negedge clk);
    chk("s5_credit_full", credit_cnt, 8);
    chk("s5_cred_err_set", cred_err, 1);
    repeat (3) tick();
    @(negedge clk);
    chk("s5_cred_err_hold", cred_err, 1);
    tick();
    do_reset();
    push_word(8'h96, 1'b0);
    req0_valid = 1'b1;
    req0_data  = 8'h96;
    credit_ret = 1'b1;
    @(negedge clk);
    chk("s5_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    credit_ret = 1'b0;
    @(negedge clk);
    chk("s5_credit_same", credit_cnt, 8);
    chk("s5_cred_err_clear", cred_err, 0);
    repeat (4) tick();

    // Reset during beat 1 discards the word.
    do_reset();
    exp_q.push_back(4'b10_0_0);
    req0_valid = 1'b1;
    req0_data  = 8'h5A;
    @(negedge clk);
    chk("s6_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("s6_lane_valid_rst", lane_valid, 0);
    chk("s6_lane_data_rst", lane_data, 0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("s6_credit_cnt", credit_cnt, 8);
    chk("s6_lane_idle", lane_valid, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
